// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the frame product accumulator.
// Holds the FSM state encoding and the longest frame length.
package product_accumulator_pkg;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator.sv
// Sums a frame of unsigned products and tracks the frame peak.
// The result and a one-cycle valid pulse are published on entry to DONE.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int PW    = 16
) (
  input  logic             clk_system,
  input  logic             rst_system,
  input  logic             start,
  input  logic [3:0]       frame_len,
  input  logic [PW-1:0]    prod_in,
  input  logic             prod_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [PW-1:0]    peak_out,
  output logic             acc_valid,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [PW-1:0]      peak_q, peak_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PW-1:0]      pk_q, pk_d;
  logic               vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    acc_d   = acc_q;
    pk_d    = pk_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (frame_len == 4'd0) ? LEN_W'(MAX_LEN)
                                        : {1'b0, frame_len};
          cnt_d   = '0;
          sum_d   = '0;
          peak_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          sum_d = sum_q + ACC_W'(prod_in);
          if (prod_in > peak_q) peak_d = prod_in;
          cnt_d = cnt_q + LEN_W'(1);
          // Publish the final values at the same edge that enters DONE
          if (cnt_d == len_q) begin
            state_d = DONE;
            acc_d   = sum_d;
            pk_d    = peak_d;
            vld_d   = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_system or posedge rst_system) begin
    if (rst_system) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      peak_q  <= '0;
      acc_q   <= '0;
      pk_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
      acc_q   <= acc_d;
      pk_q    <= pk_d;
      vld_q   <= vld_d;
    end
  end

  assign acc_out   = acc_q;
  assign peak_out  = pk_q;
  assign acc_valid = vld_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  frame_len;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic [19:0] acc_out;
  logic [15:0] peak_out;
  logic        acc_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  product_accumulator #(.ACC_W(20), .PW(16)) dut (
    .clk_system (clk),
    .rst_system (rst),
    .start      (start),
    .frame_len  (frame_len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .peak_out   (peak_out),
    .acc_valid  (acc_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts valid pulses, sampled mid-cycle
  always @(negedge clk) if (acc_valid) vcount++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start(input logic [3:0] len);
    frame_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v);
    prod_in = v;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  int v0;
  int busy_low;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_len = 4'd0;
    prod_in = '0;
    prod_valid = 1'b0;
    repeat (3) tick();
    check("rst_acc", acc_out, 0);
    check("rst_peak", peak_out, 0);
    check("rst_valid", acc_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Frame of four consecutive samples
    v0 = vcount;
    send_start(4'd4);
    check("t1_busy", busy, 1);
    feed(100); feed(200); feed(300);
    check("t1_no_early_valid", vcount - v0, 0);
    feed(400);
    check("t1_valid_latency", acc_valid, 1);
    check("t1_busy_done", busy, 0);
    check("t1_acc", acc_out, 1000);
    check("t1_peak", peak_out, 400);
    tick();
    check("t1_valid_pulse", acc_valid, 0);
    check("t1_pulses", vcount - v0, 1);

    // Sixteen maximum products with gaps
    v0 = vcount;
    busy_low = 0;
    send_start(4'd0);
    for (int i = 0; i < 16; i++) begin
      feed(16'd65025);
      if (i < 15) begin
        if (!busy) busy_low++;
        tick();
        if (!busy) busy_low++;
      end
    end
    check("t2_busy_low_cycles", busy_low, 0);
    check("t2_valid", acc_valid, 1);
    check("t2_acc", acc_out, 1040400);
    check("t2_peak", peak_out, 65025);
    tick();
    check("t2_pulses", vcount - v0, 1);

    // Start pulsed mid-frame is ignored
    v0 = vcount;
    send_start(4'd3);
    feed(5);
    start = 1'b1;
    feed(9);
    start = 1'b0;
    feed(2);
    check("t3_acc", acc_out, 16);
    check("t3_peak", peak_out, 9);
    repeat (3) tick();
    check("t3_pulses", vcount - v0, 1);
    check("t3_idle", busy, 0);

    // Reset in the middle of a frame
    v0 = vcount;
    send_start(4'd4);
    feed(50); feed(60);
    rst = 1'b1;
    #2;
    check("t4_rst_acc", acc_out, 0);
    check("t4_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("t4_no_spurious", vcount - v0, 0);
    send_start(4'd4);
    feed(1); feed(1); feed(1); feed(1);
    check("t4_valid", acc_valid, 1);
    check("t4_acc", acc_out, 4);
    check("t4_peak", peak_out, 1);
    tick();
    check("t4_pulses", vcount - v0, 1);

    // Samples in IDLE are dropped
    prod_in = 16'd500;
    prod_valid = 1'b1;
    repeat (3) tick();
    prod_valid = 1'b0;
    check("t5_idle_busy", busy, 0);
    send_start(4'd1);
    feed(7);
    check("t5_valid", acc_valid, 1);
    check("t5_acc", acc_out, 7);
    check("t5_peak", peak_out, 7);
    tick();

    // Back-to-back frames, length change mid-frame ignored
    v0 = vcount;
    send_start(4'd2);
    feed(10); feed(20);
    check("t6a_valid", acc_valid, 1);
    check("t6a_acc", acc_out, 30);
    tick();
    send_start(4'd3);
    frame_len = 4'd1;
    feed(7);
    check("t6_len_latched", acc_valid, 0);
    check("t6_hold_acc", acc_out, 30);
    check("t6_hold_peak", peak_out, 20);
    feed(5);
    check("t6_hold_acc2", acc_out, 30);
    feed(6);
    check("t6b_valid", acc_valid, 1);
    check("t6b_acc", acc_out, 18);
    check("t6b_peak", peak_out, 7);
    tick();
    check("t6_pulses", vcount - v0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
